div_ratio_monitor: RTL and testbench

//  Receiving-end checker for the on-chip integer clock dividers, including the div-by-9 50%-duty divider.

---
 rtl/div_mon_pkg.sv | 17 +
 rtl/sync_rise_det.sv | 35 +++
 rtl/div_ratio_monitor.sv | 186 ++++++++++++++++++
 tb/tb_div_ratio_monitor.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/div_mon_pkg.sv
// Shared definitions for the divider ratio monitor.
//  - mon_state_t : monitor FSM state encoding (2 bits)
//  - RATIO_DIV*  : expected periods, in source clk cycles, of the divider family
package div_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARM    = 2'd1,
        ST_MEAS   = 2'd2,
        ST_LOCKED = 2'd3
    } mon_state_t;

    localparam int RATIO_DIV9  = 9;
    localparam int RATIO_DIV12 = 12;
    localparam int RATIO_DIV80 = 80;

endpackage

// File: rtl/sync_rise_det.sv
// Synchroniser and rising-edge detector for an asynchronous input.
// Ports:
//  clk   in  1  sampling clock
//  rst   in  1  asynchronous active-high reset
//  din   in  1  asynchronous input
//  rise  out 1  registered one-cycle pulse, SYNC_STAGES+1 clk edges after a din rising edge
module sync_rise_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   prev_reg;
    logic                   rise_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_reg <= '0;
            prev_reg <= 1'b0;
            rise_reg <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], din};
            prev_reg <= sync_reg[SYNC_STAGES-1];
            // Edge pulse is registered so the consumer sees a clean flop output.
            rise_reg <= sync_reg[SYNC_STAGES-1] & ~prev_reg;
        end
    end

    assign rise = rise_reg;

endmodule

// File: rtl/div_ratio_monitor.sv
// Receiving-end checker for an integer clock divider. Measures each period of
// div_in in clk cycles, compares it with EXP_RATIO (+/- TOL) and reports lock,
// mismatch/timeout errors and a sticky stuck flag.
// Ports:
//  clk           in   1      source clock feeding the divider
//  reset         in   1      asynchronous active-high reset
//  enable        in   1      monitor enable; low forces IDLE
//  div_in        in   1      divided clock under test (asynchronous)
//  period        out  CNT_W  last measured period
//  period_valid  out  1      one-cycle pulse when period updates
//  locked        out  1      ratio confirmed
//  err           out  1      one-cycle pulse on mismatch-after-lock or timeout
//  stuck         out  1      sticky saturation flag
//  VDD, VSS      inout 1     power pins, not used by the logic
module div_ratio_monitor
    import div_mon_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8,
    parameter int EXP_RATIO   = RATIO_DIV9,
    parameter int TOL         = 0,
    parameter int LOCK_COUNT  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             div_in,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             locked,
    output logic             err,
    output logic             stuck,
    inout  wire              VDD,
    inout  wire              VSS
);

    localparam int               MC_W        = $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W:0]   EXP_EXT     = (CNT_W + 1)'(EXP_RATIO);
    localparam logic [CNT_W:0]   TOL_EXT     = (CNT_W + 1)'(TOL);
    localparam logic [MC_W-1:0]  LOCK_TARGET = MC_W'(LOCK_COUNT);

    wire unused_power = VDD ^ VSS;

    logic rise;

    sync_rise_det #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (reset),
        .din (div_in),
        .rise(rise)
    );

    mon_state_t       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [MC_W-1:0]  match_cnt_reg, match_cnt_next;
    logic [CNT_W-1:0] period_reg, period_next;
    logic             valid_reg, valid_next;
    logic             locked_reg, locked_next;
    logic             err_reg, err_next;
    logic             stuck_reg, stuck_next;

    logic             cnt_sat;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W:0]   cnt_ext;
    logic [CNT_W:0]   diff;
    logic             is_match;
    logic [MC_W-1:0]  match_inc;

    assign cnt_sat   = (cnt_reg == CNT_MAX);
    assign cnt_inc   = cnt_sat ? cnt_reg : cnt_reg + 1'b1;
    // One extra bit keeps |cnt - EXP_RATIO| from wrapping.
    assign cnt_ext   = {1'b0, cnt_reg};
    assign diff      = (cnt_ext >= EXP_EXT) ? (cnt_ext - EXP_EXT) : (EXP_EXT - cnt_ext);
    assign is_match  = (diff <= TOL_EXT);
    assign match_inc = match_cnt_reg + 1'b1;

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        match_cnt_next = match_cnt_reg;
        period_next    = period_reg;
        valid_next     = 1'b0;
        locked_next    = locked_reg;
        err_next       = 1'b0;
        stuck_next     = stuck_reg;

        if (!enable) begin
            state_next     = ST_IDLE;
            cnt_next       = '0;
            match_cnt_next = '0;
            locked_next    = 1'b0;
            stuck_next     = 1'b0;
        end else begin
            // A rise always restarts the count, even when it coincides with saturation.
            cnt_next = rise ? CNT_ONE : cnt_inc;
            unique case (state_reg)
                ST_IDLE: begin
                    cnt_next   = '0;
                    state_next = ST_ARM;
                end
                ST_ARM: begin
                    if (rise) begin
                        state_next = ST_MEAS;
                    end else if (cnt_sat && !stuck_reg) begin
                        // Only the first saturation reports; the counter then stays pinned.
                        stuck_next = 1'b1;
                        err_next   = 1'b1;
                    end
                end
                ST_MEAS: begin
                    if (rise) begin
                        period_next = cnt_reg;
                        valid_next  = 1'b1;
                        if (is_match) begin
                            match_cnt_next = match_inc;
                            if (match_inc == LOCK_TARGET) begin
                                state_next  = ST_LOCKED;
                                locked_next = 1'b1;
                            end
                        end else begin
                            match_cnt_next = '0;
                        end
                    end else if (cnt_sat) begin
                        stuck_next     = 1'b1;
                        err_next       = 1'b1;
                        locked_next    = 1'b0;
                        match_cnt_next = '0;
                        state_next     = ST_ARM;
                    end
                end
                ST_LOCKED: begin
                    if (rise) begin
                        period_next = cnt_reg;
                        valid_next  = 1'b1;
                        if (!is_match) begin
                            err_next       = 1'b1;
                            locked_next    = 1'b0;
                            match_cnt_next = '0;
                            state_next     = ST_MEAS;
                        end
                    end else if (cnt_sat) begin
                        stuck_next     = 1'b1;
                        err_next       = 1'b1;
                        locked_next    = 1'b0;
                        match_cnt_next = '0;
                        state_next     = ST_ARM;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            match_cnt_reg <= '0;
            period_reg    <= '0;
            valid_reg     <= 1'b0;
            locked_reg    <= 1'b0;
            err_reg       <= 1'b0;
            stuck_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            match_cnt_reg <= match_cnt_next;
            period_reg    <= period_next;
            valid_reg     <= valid_next;
            locked_reg    <= locked_next;
            err_reg       <= err_next;
            stuck_reg     <= stuck_next;
        end
    end

    assign period       = period_reg;
    assign period_valid = valid_reg;
    assign locked       = locked_reg;
    assign err          = err_reg;
    assign stuck        = stuck_reg;

endmodule

// File: tb/tb_div_ratio_monitor.sv
// Testbench for div_ratio_monitor: two instances (TOL=0 and TOL=1) share the
// stimulus; a timestamp-based reference model predicts every output each cycle.
module tb_div_ratio_monitor;

    localparam int SYNC  = 2;
    localparam int EXP   = 9;
    localparam int LOCKN = 4;
    localparam int MAXV  = 255;

    logic clk;
    logic reset;
    logic enable;
    logic div_in;
    wire  vdd_w;
    wire  vss_w;
    assign vdd_w = 1'b1;
    assign vss_w = 1'b0;

    logic [7:0] period_o [2];
    logic       valid_o  [2];
    logic       locked_o [2];
    logic       err_o    [2];
    logic       stuck_o  [2];

    int checks   = 0;
    int failures = 0;

    div_ratio_monitor #(.SYNC_STAGES(SYNC), .CNT_W(8), .EXP_RATIO(EXP), .TOL(0), .LOCK_COUNT(LOCKN)) dut0 (
        .clk(clk), .reset(reset), .enable(enable), .div_in(div_in),
        .period(period_o[0]), .period_valid(valid_o[0]), .locked(locked_o[0]),
        .err(err_o[0]), .stuck(stuck_o[0]), .VDD(vdd_w), .VSS(vss_w)
    );

    div_ratio_monitor #(.SYNC_STAGES(SYNC), .CNT_W(8), .EXP_RATIO(EXP), .TOL(1), .LOCK_COUNT(LOCKN)) dut1 (
        .clk(clk), .reset(reset), .enable(enable), .div_in(div_in),
        .period(period_o[1]), .period_valid(valid_o[1]), .locked(locked_o[1]),
        .err(err_o[1]), .stuck(stuck_o[1]), .VDD(vdd_w), .VSS(vss_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a measurement is the time between consecutive detected
    // edges, capped at MAXV; lock is a run of LOCKN in-tolerance measurements.
    int tol_m [2] = '{0, 1};
    int edge_n = 0;
    bit hist [0:7];
    bit running [2];
    bit seen_first [2];
    bit lock_m [2];
    bit stuck_m [2];
    bit valid_m [2];
    bit err_m [2];
    int good_run [2];
    int last_ref [2];
    int per_m [2];

    task automatic model_reset();
        for (int j = 0; j < 8; j++) hist[j] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            running[i] = 0; seen_first[i] = 0; lock_m[i] = 0; stuck_m[i] = 0;
            valid_m[i] = 0; err_m[i] = 0; good_run[i] = 0; last_ref[i] = 0; per_m[i] = 0;
        end
    endtask

    task automatic model_edge();
        bit r;
        int el;
        int dev;
        // The monitor acts on a div_in edge SYNC+1 clock edges after first sampling it high.
        r = hist[SYNC] && !hist[SYNC+1];
        for (int i = 0; i < 2; i++) begin
            valid_m[i] = 0;
            err_m[i]   = 0;
            if (!enable) begin
                running[i] = 0; seen_first[i] = 0; good_run[i] = 0; lock_m[i] = 0; stuck_m[i] = 0;
            end else if (!running[i]) begin
                running[i]    = 1;
                seen_first[i] = 0;
                last_ref[i]   = edge_n + 1;
            end else begin
                el = edge_n - last_ref[i];
                if (el > MAXV) el = MAXV;
                if (r) begin
                    if (seen_first[i]) begin
                        per_m[i]   = el;
                        valid_m[i] = 1;
                        dev = (el > EXP) ? el - EXP : EXP - el;
                        if (dev <= tol_m[i]) begin
                            if (!lock_m[i]) begin
                                good_run[i]++;
                                if (good_run[i] >= LOCKN) lock_m[i] = 1;
                            end
                        end else begin
                            if (lock_m[i]) err_m[i] = 1;
                            lock_m[i]   = 0;
                            good_run[i] = 0;
                        end
                    end
                    seen_first[i] = 1;
                    last_ref[i]   = edge_n;
                end else if (el == MAXV && (seen_first[i] || !stuck_m[i])) begin
                    err_m[i] = 1; stuck_m[i] = 1; lock_m[i] = 0; good_run[i] = 0; seen_first[i] = 0;
                end
            end
        end
        for (int j = 7; j > 0; j--) hist[j] = hist[j-1];
        hist[0] = div_in;
        edge_n++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("i%0d_period", i), 32'(period_o[i]), per_m[i]);
            chk($sformatf("i%0d_valid", i),  32'(valid_o[i]),  32'(valid_m[i]));
            chk($sformatf("i%0d_locked", i), 32'(locked_o[i]), 32'(lock_m[i]));
            chk($sformatf("i%0d_err", i),    32'(err_o[i]),    32'(err_m[i]));
            chk($sformatf("i%0d_stuck", i),  32'(stuck_o[i]),  32'(stuck_m[i]));
        end
        if (valid_o[0] === 1'b1)
            $display("txn t=%0t inst0 period=%0d locked=%0d err=%0d inst1 locked=%0d err=%0d",
                     $time, period_o[0], locked_o[0], err_o[0], locked_o[1], err_o[1]);
    endtask

    task automatic cycle();
        @(posedge clk);
        if (reset) model_reset();
        else model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic tick(input logic d);
        div_in = d;
        cycle();
    endtask

    task automatic drive_period(input int p);
        for (int k = 0; k < p; k++) tick(k < (p + 1) / 2);
    endtask

    initial begin
        int sel;
        reset  = 1'b1;
        enable = 1'b0;
        div_in = 1'b0;
        model_reset();
        cycle();
        cycle();
        reset = 1'b0;
        cycle();
        enable = 1'b1;

        // Clean lock on div-by-9
        repeat (8) drive_period(9);
        chk("t1_locked", 32'(locked_o[0]), 1);

        // Single long period after lock, then relock
        drive_period(10);
        repeat (7) drive_period(9);
        chk("t2_relocked", 32'(locked_o[0]), 1);

        // div_in held low after lock -> timeout
        repeat (270) tick(1'b0);
        chk("t3_stuck", 32'(stuck_o[0]), 1);
        chk("t3_unlocked", 32'(locked_o[0]), 0);
        repeat (7) drive_period(9);

        // enable dropped for 3 cycles mid-lock
        enable = 1'b0;
        tick(1'b1);
        chk("t4_drop_locked", 32'(locked_o[0]), 0);
        chk("t4_drop_stuck", 32'(stuck_o[0]), 0);
        tick(1'b1);
        tick(1'b1);
        enable = 1'b1;
        tick(1'b1);
        repeat (5) tick(1'b0);
        repeat (7) drive_period(9);

        // Asynchronous reset between clock edges while locked
        #2 reset = 1'b1;
        #1;
        chk("t5_async_locked", 32'(locked_o[0]), 0);
        chk("t5_async_period", 32'(period_o[0]), 0);
        chk("t5_async_stuck", 32'(stuck_o[1]), 0);
        model_reset();
        cycle();
        cycle();
        reset = 1'b0;
        repeat (7) drive_period(9);

        // Alternating 8/10 (locks only with TOL=1), then an 11
        repeat (3) begin
            drive_period(8);
            drive_period(10);
        end
        drive_period(11);
        repeat (6) drive_period(9);

        // Saturation boundaries: 255 collides with saturation, 256 times out
        drive_period(255);
        repeat (6) drive_period(9);
        drive_period(256);
        repeat (6) drive_period(9);

        // Randomized mix
        for (int k = 0; k < 60; k++) begin
            sel = $urandom_range(0, 15);
            if (sel < 9) drive_period(9);
            else if (sel < 11) drive_period(8);
            else if (sel < 13) drive_period(10);
            else if (sel == 13) drive_period($urandom_range(2, 30));
            else if (sel == 14) drive_period(11);
            else begin
                enable = 1'b0;
                repeat ($urandom_range(1, 4)) tick(div_in);
                enable = 1'b1;
            end
        end
        repeat (20) tick(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
